// File: rtl/lc3b_types.sv
// Shared types for the LC-3b memory system: 128-bit lines, line addressing
// and the Wishbone memory slave state encoding.
package lc3b_types;

  localparam int LINE_W      = 128;
  localparam int LINE_ADDR_W = 12;
  localparam int LINE_SEL_W  = 16;

  typedef logic [LINE_W-1:0]      lc3b_line;
  typedef logic [LINE_ADDR_W-1:0] lc3b_line_addr;
  typedef logic [LINE_SEL_W-1:0]  lc3b_line_sel;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } wb_slave_state_t;

  // True when a line address is backed by storage of the given depth.
  function automatic logic addr_in_range(lc3b_line_addr adr, int depth);
    return int'({20'd0, adr}) < depth;
  endfunction

endpackage

// File: rtl/wishbone_memory_slave_line_storage.sv
// Line-organised backing store: byte-enable synchronous write,
// combinational read.
module line_storage
  import lc3b_types::*;
#(
  parameter int DEPTH     = 256,
  parameter int AW        = 8,
  parameter     INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  lc3b_line_sel  wr_sel,
  input  lc3b_line      wr_data,
  input  logic [AW-1:0] rd_addr,
  output lc3b_line      rd_data
);

  lc3b_line mem [DEPTH];
  lc3b_line merged;

  // Lanes not selected keep the stored byte, so one full-line write commits the merge.
  genvar gi;
  generate
    for (gi = 0; gi < LINE_SEL_W; gi++) begin : g_lane
      assign merged[8*gi +: 8] = wr_sel[gi] ? wr_data[8*gi +: 8] : mem[wr_addr][8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= merged;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/wishbone_memory_slave.sv
// Wishbone classic-cycle memory responder with programmable wait states,
// byte-lane writes, retry on out-of-range lines and saturating perf counters.
module wishbone_memory_slave
  import lc3b_types::*;
#(
  parameter int LATENCY   = 3,
  parameter int DEPTH     = 256,
  parameter     INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_cyc,
  input  logic          wb_stb,
  input  logic          wb_we,
  input  lc3b_line_addr wb_adr,
  input  lc3b_line_sel  wb_sel,
  input  lc3b_line      wb_dat_m,
  output lc3b_line      wb_dat_s,
  output logic          wb_ack,
  output logic          wb_rty,
  output logic [31:0]   perf_reads,
  output logic [31:0]   perf_writes
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_slave_state_t state_reg, state_next;
  logic [3:0]      cnt_reg, cnt_next;
  lc3b_line_addr   adr_reg;
  logic            we_reg;
  lc3b_line_sel    sel_reg;
  lc3b_line        dat_reg;
  logic            ack_reg, rty_reg;
  lc3b_line        dat_s_reg;
  logic [31:0]     reads_reg, writes_reg;

  logic          req, accept, enter_resp;
  lc3b_line_addr eff_adr;
  logic          eff_we, eff_in_range, resp_in_range, store_en;
  lc3b_line      rd_line;

  assign req    = wb_cyc & wb_stb;
  assign accept = (state_reg == IDLE) & req;

  // With LATENCY=1 the response is decided on the accepting edge, before the latches hold anything.
  assign eff_adr       = (state_reg == IDLE) ? wb_adr : adr_reg;
  assign eff_we        = (state_reg == IDLE) ? wb_we  : we_reg;
  assign eff_in_range  = addr_in_range(eff_adr, DEPTH);
  assign resp_in_range = addr_in_range(adr_reg, DEPTH);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (LATENCY <= 1) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg <= 4'd1) begin
          state_next = RESP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign enter_resp = (state_next == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      adr_reg    <= '0;
      we_reg     <= 1'b0;
      sel_reg    <= '0;
      dat_reg    <= '0;
      ack_reg    <= 1'b0;
      rty_reg    <= 1'b0;
      dat_s_reg  <= '0;
      reads_reg  <= '0;
      writes_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        adr_reg <= wb_adr;
        we_reg  <= wb_we;
        sel_reg <= wb_sel;
        dat_reg <= wb_dat_m;
      end
      ack_reg <= enter_resp & eff_in_range;
      rty_reg <= enter_resp & ~eff_in_range;
      if (enter_resp && eff_in_range) begin
        if (eff_we) begin
          if (writes_reg != '1) writes_reg <= writes_reg + 32'd1;
        end else begin
          dat_s_reg <= rd_line;
          if (reads_reg != '1) reads_reg <= reads_reg + 32'd1;
        end
      end
    end
  end

  // The write lands on the edge that closes RESP, so an abort or reset never touches storage.
  assign store_en = (state_reg == RESP) & we_reg & resp_in_range;

  line_storage #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .INIT_FILE(INIT_FILE)
  ) u_storage (
    .clk    (clk),
    .wr_en  (store_en),
    .wr_addr(adr_reg[AW-1:0]),
    .wr_sel (sel_reg),
    .wr_data(dat_reg),
    .rd_addr(eff_adr[AW-1:0]),
    .rd_data(rd_line)
  );

  assign wb_ack      = ack_reg;
  assign wb_rty      = rty_reg;
  assign wb_dat_s    = dat_s_reg;
  assign perf_reads  = reads_reg;
  assign perf_writes = writes_reg;

endmodule
